// File: rtl/uart_tx_arb_if.sv
`timescale 1ns/1ps
// uart_tx_arb_if: bundles the two requester byte streams and the UART
// register bus. The arbiter is the master; requesters plus UART form the slave.
interface uart_tx_arb_if;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        ucs;
  logic        uwen;
  logic [3:0]  uaddr;
  logic [31:0] udin;
  logic [31:0] udout;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, udout,
    output req0_ready, req1_ready, ucs, uwen, uaddr, udin
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, udout,
    input  req0_ready, req1_ready, ucs, uwen, uaddr, udin
  );
endinterface

// File: rtl/uart_tx_arb.sv
`timescale 1ns/1ps
// uart_tx_arb: configures the UART once after reset, then shares its
// transmitter between two byte-stream requesters with line-granular locking.
// Every data write is preceded by a status poll until TXE reads back as 1.
module uart_tx_arb #(
  parameter logic [3:0]  CFG_ADDR     = 4'd1,
  parameter logic [31:0] CFG_VAL      = 32'd3,
  parameter logic [3:0]  DATA_ADDR    = 4'd0,
  parameter logic [3:0]  STAT_ADDR    = 4'd3,
  parameter int          TXE_BIT      = 0,
  parameter logic [7:0]  EOL          = 8'h0a,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd1000
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_arb_if.master bus,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam logic [2:0] S_CFG   = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_POLL  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]  state_reg, state_next;
  logic [7:0]  byte_reg;
  logic        owner_reg;      // requester index of the byte in flight / lock owner
  logic        rr_reg;         // requester that wins an unlocked tie
  logic [1:0]  grant_reg;
  logic [15:0] idle_cnt_reg;
  logic        busy_reg;
  logic [3:0]  uaddr_reg;      // hold registers so the bus keeps its last value
  logic [31:0] udin_reg;

  logic        ucs_c, uwen_c;
  logic [3:0]  uaddr_c;
  logic [31:0] udin_c;

  logic        locked;
  logic        owner_valid;
  logic        win;
  logic        win_id;
  logic [7:0]  win_data;
  logic        accept;
  logic        timeout_hit;
  logic        txe;
  logic        unused_udout;

  assign locked       = |grant_reg;
  assign owner_valid  = owner_reg ? bus.req1_valid : bus.req0_valid;
  assign txe          = bus.udout[TXE_BIT];
  assign unused_udout = ^bus.udout;

  // Winner selection: a held lock always belongs to its owner; otherwise a lone
  // valid requester wins and a tie goes to the round-robin favourite.
  always_comb begin
    win    = 1'b0;
    win_id = rr_reg;
    if (locked) begin
      win_id = owner_reg;
      win    = owner_valid;
    end else if (bus.req0_valid && bus.req1_valid) begin
      win    = 1'b1;
      win_id = rr_reg;
    end else if (bus.req0_valid) begin
      win    = 1'b1;
      win_id = 1'b0;
    end else if (bus.req1_valid) begin
      win    = 1'b1;
      win_id = 1'b1;
    end
  end

  assign win_data       = win_id ? bus.req1_data : bus.req0_data;
  assign accept         = (state_reg == S_IDLE) && win && !reset;
  assign bus.req0_ready = accept && !win_id;
  assign bus.req1_ready = accept && win_id;
  assign timeout_hit    = (state_reg == S_IDLE) && locked && !owner_valid &&
                          (idle_cnt_reg >= LOCK_TIMEOUT);

  // Next-state logic; TXE=0 in CHECK sends us back to POLL without limit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CFG:   state_next = S_IDLE;
      S_IDLE:  state_next = win ? S_POLL : S_IDLE;
      S_POLL:  state_next = S_CHECK;
      S_CHECK: state_next = txe ? S_WRITE : S_POLL;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_CFG;
    endcase
  end

  // Bus drive decoded from state; reset forces the bus quiet so an in-flight
  // POLL or WRITE never pulses ucs while reset is held.
  always_comb begin
    ucs_c   = 1'b0;
    uwen_c  = 1'b0;
    uaddr_c = uaddr_reg;
    udin_c  = udin_reg;
    if (reset) begin
      uaddr_c = 4'd0;
      udin_c  = 32'd0;
    end else begin
      case (state_reg)
        S_CFG: begin
          ucs_c   = 1'b1;
          uwen_c  = 1'b1;
          uaddr_c = CFG_ADDR;
          udin_c  = CFG_VAL;
        end
        S_POLL: begin
          ucs_c   = 1'b1;
          uaddr_c = STAT_ADDR;
        end
        S_WRITE: begin
          ucs_c   = 1'b1;
          uwen_c  = 1'b1;
          uaddr_c = DATA_ADDR;
          udin_c  = {24'd0, byte_reg};
        end
        default: ;
      endcase
    end
  end

  assign bus.ucs   = ucs_c;
  assign bus.uwen  = uwen_c;
  assign bus.uaddr = uaddr_c;
  assign bus.udin  = udin_c;
  assign grant     = grant_reg;
  assign busy      = busy_reg;

  // State register, registered busy flag and bus hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_CFG;
      busy_reg  <= 1'b1;
      uaddr_reg <= 4'd0;
      udin_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != S_IDLE);
      uaddr_reg <= uaddr_c;
      udin_reg  <= udin_c;
    end
  end

  // Byte capture, lock ownership, round-robin pointer and idle-timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_reg     <= 8'd0;
      owner_reg    <= 1'b0;
      rr_reg       <= 1'b0;
      grant_reg    <= 2'b00;
      idle_cnt_reg <= 16'd0;
    end else begin
      if (state_reg == S_IDLE) begin
        if (win) begin
          byte_reg     <= win_data;
          owner_reg    <= win_id;
          idle_cnt_reg <= 16'd0;
        end else if (timeout_hit) begin
          grant_reg    <= 2'b00;
          rr_reg       <= ~owner_reg;
          idle_cnt_reg <= 16'd0;
        end else if (locked) begin
          idle_cnt_reg <= idle_cnt_reg + 16'd1;
        end
      end
      if (state_reg == S_WRITE) begin
        if (byte_reg == EOL) begin
          grant_reg <= 2'b00;
          rr_reg    <= ~owner_reg;
        end else begin
          grant_reg <= owner_reg ? 2'b10 : 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
`timescale 1ns/1ps
// tb_uart_tx_arb: scoreboard bench. Accepted bytes are checked against the
// expected arbitration order, then queued and matched against UART data writes
// for value, latency and poll count. A small UART model answers status polls.
module tb_uart_tx_arb;

  typedef struct { logic id; logic [7:0] data; } exp_t;
  typedef struct { logic id; logic [7:0] data; int cyc; int zeros; int polls; } sb_t;
  typedef struct { logic [1:0] g; int cyc; } glog_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] grant;
  logic busy;

  uart_tx_arb_if bus();

  uart_tx_arb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int zero_count = 0;
  int poll_count = 0;
  int cfg_count = 0;
  int data_writes = 0;
  int txe_zeros = 0;
  logic poll_flag = 1'b0;
  logic fire0 = 1'b0, fire1 = 1'b0;
  logic prev_ucs = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic grant_pending = 1'b0;
  logic [1:0] grant_exp = 2'b00;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  exp_t  exp_q[$];
  sb_t   sb[$];
  glog_t glog[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic accept_byte(input logic id, input logic [7:0] data);
    exp_t e;
    sb_t  s;
    check_eq("one_in_flight", sb.size(), 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("arb_id", {31'd0, id}, {31'd0, e.id});
      check_eq("arb_data", {24'd0, data}, {24'd0, e.data});
    end else begin
      check_eq("exp_avail", exp_q.size(), 1);
    end
    s.id = id; s.data = data; s.cyc = cyc; s.zeros = zero_count; s.polls = poll_count;
    sb.push_back(s);
  endtask

  // Monitor and UART model, sampling mid-cycle on the falling edge.
  initial begin
    sb_t s;
    glog_t gl;
    bus.udout = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        check_eq("rst_ucs", {31'd0, bus.ucs}, 0);
        check_eq("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
        prev_ucs = 1'b0;
        prev_grant = grant;
        grant_pending = 1'b0;
      end else begin
        check_eq("two_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
        check_eq("ucs_b2b", {31'd0, bus.ucs & prev_ucs}, 0);
        if (bus.req0_valid && bus.req0_ready) begin
          fire0 = 1'b1;
          accept_byte(1'b0, bus.req0_data);
        end
        if (bus.req1_valid && bus.req1_ready) begin
          fire1 = 1'b1;
          accept_byte(1'b1, bus.req1_data);
        end
        if (grant_pending) begin
          check_eq("grant_after_write", {30'd0, grant}, {30'd0, grant_exp});
          grant_pending = 1'b0;
        end
        if (bus.ucs && bus.uwen && bus.uaddr == 4'd0) begin
          data_writes++;
          if (sb.size() > 0) begin
            s = sb.pop_front();
            $display("write req%0d data=%02h latency=%0d", s.id, bus.udin[7:0], cyc - s.cyc);
            check_eq("wr_data", bus.udin, {24'd0, s.data});
            check_eq("wr_latency", cyc - s.cyc, 3 + 2 * (zero_count - s.zeros));
            check_eq("wr_polls", poll_count - s.polls, 1 + zero_count - s.zeros);
            grant_exp = (s.data == 8'h0a) ? 2'b00 : (s.id ? 2'b10 : 2'b01);
            grant_pending = 1'b1;
          end else begin
            check_eq("wr_expected", sb.size(), 1);
          end
        end
        if (bus.ucs && bus.uwen && bus.uaddr == 4'd1) begin
          cfg_count++;
          check_eq("cfg_din", bus.udin, 32'd3);
        end
        if (bus.ucs && !bus.uwen) begin
          check_eq("poll_addr", {28'd0, bus.uaddr}, 32'd3);
          poll_count++;
          poll_flag = 1'b1;
          if (txe_zeros > 0) begin
            txe_zeros--;
            zero_count++;
            bus.udout = $urandom() & 32'hffff_fffe;
          end else begin
            bus.udout = $urandom() | 32'h0000_0001;
          end
        end
        if (grant != prev_grant) begin
          gl.g = grant; gl.cyc = cyc;
          glog.push_back(gl);
        end
        prev_ucs = bus.ucs;
        prev_grant = grant;
      end
    end
  end

  // Requester sources: hold a byte until its handshake, then present the next.
  initial begin
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (fire0 && q0.size() > 0) q0.delete(0);
      if (fire1 && q1.size() > 0) q1.delete(0);
      fire0 = 1'b0;
      fire1 = 1'b0;
      bus.req0_valid = (q0.size() > 0);
      bus.req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
      bus.req1_valid = (q1.size() > 0);
      bus.req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    end
  end

  // Called and returns at posedge+3ns; asserts reset immediately.
  task automatic do_reset();
    int cfg_before;
    reset = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete(); sb.delete();
    txe_zeros = 0;
    fire0 = 1'b0; fire1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_uaddr", {28'd0, bus.uaddr}, 0);
    check_eq("rst_udin", bus.udin, 0);
    @(posedge clk);
    #3;
    glog.delete();
    cfg_before = cfg_count;
    reset = 1'b0;
    @(negedge clk);
    check_eq("cfg_ucs", {31'd0, bus.ucs}, 1);
    check_eq("cfg_uwen", {31'd0, bus.uwen}, 1);
    check_eq("cfg_uaddr", {28'd0, bus.uaddr}, 1);
    check_eq("cfg_udin", bus.udin, 3);
    @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 0);
    check_eq("idle_grant", {30'd0, grant}, 0);
    check_eq("cfg_once", cfg_count - cfg_before, 1);
    @(posedge clk);
    #3;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((q0.size() + q1.size() + exp_q.size() + sb.size()) != 0 && n < max_cyc) begin
      @(posedge clk);
      #3;
      n++;
    end
    check_eq("drain", q0.size() + q1.size() + exp_q.size() + sb.size(), 0);
    repeat (2) @(posedge clk);
    #3;
  endtask

  task automatic expect_byte(input logic id, input logic [7:0] data);
    exp_t e;
    e.id = id; e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_err);
    $fatal(1);
  end

  initial begin
    int wbefore;
    int n;
    @(posedge clk);
    #3;

    // Reset, then idle: bus stays quiet.
    do_reset();
    repeat (5) begin
      @(negedge clk);
      check_eq("idle_ucs", {31'd0, bus.ucs}, 0);
    end
    @(posedge clk);
    #3;

    // Single byte from req0, TXE ready immediately.
    q0.push_back(8'h6d); expect_byte(1'b0, 8'h6d);
    wait_drain(50);
    check_eq("s2_grant", {30'd0, grant}, 2'b01);

    // Three not-ready polls before the write.
    txe_zeros = 3;
    q0.push_back(8'h21); expect_byte(1'b0, 8'h21);
    wait_drain(80);
    check_eq("s3_zeros_used", txe_zeros, 0);

    // req0 sends a whole line while req1 waits with 0x67.
    do_reset();
    q0.push_back(8'h6d); q0.push_back(8'h20); q0.push_back(8'h30); q0.push_back(8'h0a);
    q1.push_back(8'h67);
    expect_byte(1'b0, 8'h6d); expect_byte(1'b0, 8'h20);
    expect_byte(1'b0, 8'h30); expect_byte(1'b0, 8'h0a);
    expect_byte(1'b1, 8'h67);
    wait_drain(200);
    check_eq("s4_glog_n", glog.size(), 3);
    if (glog.size() == 3) begin
      check_eq("s4_g0", {30'd0, glog[0].g}, 2'b01);
      check_eq("s4_g1", {30'd0, glog[1].g}, 2'b00);
      check_eq("s4_g2", {30'd0, glog[2].g}, 2'b10);
    end

    // Both streams of EOL bytes from reset alternate, req0 first.
    do_reset();
    repeat (3) begin
      q0.push_back(8'h0a);
      q1.push_back(8'h0a);
      expect_byte(1'b0, 8'h0a);
      expect_byte(1'b1, 8'h0a);
    end
    wait_drain(200);
    check_eq("s5_glog_n", glog.size(), 0);

    // Lock req1, then let the idle timeout release it so req0 is served.
    do_reset();
    q1.push_back(8'h41); expect_byte(1'b1, 8'h41);
    wait_drain(50);
    check_eq("s6_locked", {30'd0, grant}, 2'b10);
    q0.push_back(8'h42); expect_byte(1'b0, 8'h42);
    wait_drain(1300);
    check_eq("s6_glog_n", glog.size(), 3);
    if (glog.size() == 3) begin
      n = glog[1].cyc - glog[0].cyc;
      check_eq("s6_g_locked", {30'd0, glog[0].g}, 2'b10);
      check_eq("s6_g_released", {30'd0, glog[1].g}, 2'b00);
      check_eq("s6_timeout_window", {31'd0, (n >= 999 && n <= 1003)}, 1);
      check_eq("s6_g_req0", {30'd0, glog[2].g}, 2'b01);
    end

    // Reset during CHECK drops the byte and repeats CFG.
    do_reset();
    poll_flag = 1'b0;
    q0.push_back(8'h55); expect_byte(1'b0, 8'h55);
    n = 0;
    while (!poll_flag && n < 50) begin
      @(posedge clk);
      #3;
      n++;
    end
    check_eq("s7_poll_seen", {31'd0, poll_flag}, 1);
    wbefore = data_writes;
    do_reset();
    check_eq("s7_no_write", data_writes - wbefore, 0);
    q0.push_back(8'h0a); expect_byte(1'b0, 8'h0a);
    wait_drain(50);
    check_eq("s7_recover_writes", data_writes - wbefore, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
